// File: rtl/mult_serial_digit_ctrl.sv
// Digit-serial MxN multiplier: latches the parallel operand on start, consumes the
// serial operand D bits per cycle and streams the (N+M)-bit product LSB digit first.
module mult_serial_digit_ctrl #(
  parameter int N      = 32,
  parameter int M      = 32,
  parameter int D      = 1,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] e_init,
  input  logic [D-1:0] g_input,
  output logic [D-1:0] o,
  output logic         o_valid,
  output logic         busy,
  output logic         done
);

  localparam int W  = M + D + 1;
  localparam int T  = (N + M) / D;
  localparam int CW = $clog2(T + 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(N / D - 1);
  localparam logic [CW-1:0] OP_LAST   = CW'(T - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t        state;
  logic [M-1:0]  e_q;
  logic [W-1:0]  p_q;
  logic [CW-1:0] cnt;

  logic          accept;
  logic [D-1:0]  g;
  logic          neg_msb;
  logic          e_sign;
  logic          s_sign;
  logic [W-1:0]  e_ext;
  logic [W-1:0]  s;
  logic [W-1:0]  p_next;

  // done marks the last digit, so a start in that cycle chains the next operation
  assign accept = start && (!busy || done);

  // Shift-add of one digit; in signed mode the MSB of the final serial digit weighs negative
  always_comb begin
    g       = (state == LOAD) ? g_input : '0;
    neg_msb = (SIGNED != 0) && (state == LOAD) && (cnt == LOAD_LAST);
    e_sign  = (SIGNED != 0) && e_q[M-1];
    e_ext   = {{(W-M){e_sign}}, e_q};
    s       = p_q;
    for (int unsigned i = 0; i < unsigned'(D); i++) begin
      if (g[i]) begin
        if (neg_msb && (i == unsigned'(D - 1)))
          s = s - (e_ext << i);
        else
          s = s + (e_ext << i);
      end
    end
    s_sign = (SIGNED != 0) && s[W-1];
    p_next = {{D{s_sign}}, s[W-1:D]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      e_q     <= '0;
      p_q     <= '0;
      cnt     <= '0;
      o       <= '0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      o       <= '0;
      o_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          // busy lingers into the done cycle (state already IDLE) and drops after it
          if (accept) begin
            state <= LOAD;
            e_q   <= e_init;
            p_q   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD, FLUSH: begin
          o       <= s[D-1:0];
          o_valid <= 1'b1;
          p_q     <= p_next;
          cnt     <= cnt + CW'(1);
          if (cnt == OP_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (cnt == LOAD_LAST) begin
            state <= FLUSH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_serial_digit_ctrl.sv
// Directed bench: four 8x8 instances (D=1,2,4 unsigned, D=2 signed) run in lockstep
// from a vector table, plus back-to-back, mid-op start, reset and 1024-bit cases.
module tb_mult_serial_digit_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [7:0] e8;
  logic       g1;
  logic [1:0] g2, gs;
  logic [3:0] g4;
  logic       o1;
  logic [1:0] o2, os;
  logic [3:0] o4;
  logic       ov1, ov2, ov4, ovs, bz1, bz2, bz4, bzs, dn1, dn2, dn4, dns;

  logic          start_l, g_l, o_l, ov_l, bz_l, dn_l;
  logic [1023:0] e_l;

  mult_serial_digit_ctrl #(.N(8), .M(8), .D(1), .SIGNED(0)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .e_init(e8), .g_input(g1),
    .o(o1), .o_valid(ov1), .busy(bz1), .done(dn1));
  mult_serial_digit_ctrl #(.N(8), .M(8), .D(2), .SIGNED(0)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .e_init(e8), .g_input(g2),
    .o(o2), .o_valid(ov2), .busy(bz2), .done(dn2));
  mult_serial_digit_ctrl #(.N(8), .M(8), .D(4), .SIGNED(0)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .e_init(e8), .g_input(g4),
    .o(o4), .o_valid(ov4), .busy(bz4), .done(dn4));
  mult_serial_digit_ctrl #(.N(8), .M(8), .D(2), .SIGNED(1)) u_s2 (
    .clk(clk), .rst(rst), .start(start), .e_init(e8), .g_input(gs),
    .o(os), .o_valid(ovs), .busy(bzs), .done(dns));
  mult_serial_digit_ctrl #(.N(1024), .M(1024), .D(1), .SIGNED(0)) u_big (
    .clk(clk), .rst(rst), .start(start_l), .e_init(e_l), .g_input(g_l),
    .o(o_l), .o_valid(ov_l), .busy(bz_l), .done(dn_l));

  logic       ov_a[4], bz_a[4], dn_a[4];
  logic [3:0] od_a[4];
  assign ov_a[0] = ov1;  assign ov_a[1] = ov2;  assign ov_a[2] = ov4;  assign ov_a[3] = ovs;
  assign bz_a[0] = bz1;  assign bz_a[1] = bz2;  assign bz_a[2] = bz4;  assign bz_a[3] = bzs;
  assign dn_a[0] = dn1;  assign dn_a[1] = dn2;  assign dn_a[2] = dn4;  assign dn_a[3] = dns;
  assign od_a[0] = {3'b000, o1};
  assign od_a[1] = {2'b00, o2};
  assign od_a[2] = o4;
  assign od_a[3] = {2'b00, os};

  int checks = 0;
  int errors = 0;

  logic [15:0] prod[4];
  int vcnt[4], first_v[4], done_c[4], ndone[4], busy_err[4];

  typedef struct {
    logic [7:0]  e;
    logic [7:0]  g;
    logic [15:0] pu;
    logic [15:0] ps;
  } vec_t;
  vec_t vecs[10];

  logic [31:0]   stream;
  int            vbits, busy_drop, nd, dc1, dc2, bad;
  logic [2047:0] stream_l, ref_l;
  int            vb_l, dc_l, nd_l;

  function automatic int dwidth(input int i);
    case (i)
      0:       return 1;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      prod[i] = '0; vcnt[i] = 0; first_v[i] = -1;
      done_c[i] = 0; ndone[i] = 0; busy_err[i] = 0;
    end
  endtask

  task automatic sample(input int t);
    int w, td, idx;
    for (int i = 0; i < 4; i++) begin
      w  = dwidth(i);
      td = 16 / w;
      if (ov_a[i]) begin
        if (first_v[i] < 0) first_v[i] = t;
        for (int b = 0; b < w; b++) begin
          idx = vcnt[i] * w + b;
          if (idx < 16) prod[i][idx] = od_a[i][b];
        end
        vcnt[i]++;
      end
      if (dn_a[i]) begin
        done_c[i] = t;
        ndone[i]++;
      end
      if (bz_a[i] !== (t >= 1 && t <= td + 1)) busy_err[i]++;
    end
  endtask

  task automatic drive_digits(input logic [7:0] g, input int k);
    g1 = 1'b0; g2 = '0; g4 = '0; gs = '0;
    if (k >= 0 && k < 8) g1 = g[k];
    if (k >= 0 && k < 4) begin
      g2 = g[2*k +: 2];
      gs = g[2*k +: 2];
    end
    if (k >= 0 && k < 2) g4 = g[4*k +: 4];
  endtask

  task automatic run8(input logic [7:0] e, input logic [7:0] g, input logic [15:0] exp_u,
                      input logic [15:0] exp_s, input int glitch_t, input string tag);
    int td;
    clear_stats();
    @(negedge clk);
    e8 = e; start = 1'b1; drive_digits(8'h00, -1);
    for (int t = 1; t <= 19; t++) begin
      @(negedge clk);
      sample(t);
      start = (t == glitch_t);
      e8    = (t == glitch_t) ? 8'h55 : ~e;
      drive_digits(g, t - 1);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      td = 16 / dwidth(i);
      chk($sformatf("%s dut%0d product", tag, i), prod[i], (i == 3) ? exp_s : exp_u);
      chk($sformatf("%s dut%0d valid_count", tag, i), vcnt[i], td);
      chk($sformatf("%s dut%0d first_valid", tag, i), first_v[i], 2);
      chk($sformatf("%s dut%0d done_cycle", tag, i), done_c[i], td + 1);
      chk($sformatf("%s dut%0d done_count", tag, i), ndone[i], 1);
      chk($sformatf("%s dut%0d busy_profile_errs", tag, i), busy_err[i], 0);
    end
  endtask

  initial begin
    vecs[0] = '{e: 8'hAA, g: 8'hFF, pu: 16'hA956, ps: 16'h0056};
    vecs[1] = '{e: 8'h80, g: 8'h80, pu: 16'h4000, ps: 16'h4000};
    vecs[2] = '{e: 8'hFF, g: 8'h05, pu: 16'h04FB, ps: 16'hFFFB};
    vecs[3] = '{e: 8'h7F, g: 8'h80, pu: 16'h3F80, ps: 16'hC080};
    vecs[4] = '{e: 8'h80, g: 8'h7F, pu: 16'h3F80, ps: 16'hC080};
    vecs[5] = '{e: 8'h03, g: 8'h05, pu: 16'h000F, ps: 16'h000F};
    vecs[6] = '{e: 8'hFF, g: 8'hFF, pu: 16'hFE01, ps: 16'h0001};
    vecs[7] = '{e: 8'h01, g: 8'h80, pu: 16'h0080, ps: 16'hFF80};
    vecs[8] = '{e: 8'h00, g: 8'hFF, pu: 16'h0000, ps: 16'h0000};
    vecs[9] = '{e: 8'h12, g: 8'h34, pu: 16'h03A8, ps: 16'h03A8};

    rst = 1'b1; start = 1'b0; e8 = '0; drive_digits(8'h00, -1);
    start_l = 1'b0; e_l = '0; g_l = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset dut%0d outputs", i), {od_a[i], ov_a[i], bz_a[i], dn_a[i]}, 0);
    chk("reset big outputs", {o_l, ov_l, bz_l, dn_l}, 0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++)
      run8(vecs[v].e, vecs[v].g, vecs[v].pu, vecs[v].ps, 0, $sformatf("vec%0d", v));

    // start pulsed while every instance is mid-operation must be ignored
    run8(8'hAA, 8'hFF, 16'hA956, 16'h0056, 4, "glitch");

    // back-to-back on the D=1 instance: A=0x03*0x05, B=0x0C*0x0A started in A's done cycle
    stream = '0; vbits = 0; busy_drop = 0; nd = 0; dc1 = 0; dc2 = 0;
    @(negedge clk);
    e8 = 8'h03; start = 1'b1; drive_digits(8'h00, -1);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (ov1) begin
        if (vbits < 32) stream[vbits] = o1;
        vbits++;
      end
      if (t == 18) chk("b2b gap_cycle o_valid", ov1, 0);
      if (t == 35) chk("b2b busy after B", bz1, 0);
      if (dn1) begin
        nd++;
        if (nd == 1) dc1 = t; else dc2 = t;
      end
      if (t <= 34 && !bz1) busy_drop++;
      start = (t == 17);
      e8    = (t == 17) ? 8'h0C : 8'h00;
      g1    = 1'b0;
      if (t >= 1 && t <= 8)   g1 = (8'h05 >> (t - 1)) & 8'h01;
      if (t >= 18 && t <= 25) g1 = (8'h0A >> (t - 18)) & 8'h01;
    end
    start = 1'b0;
    chk("b2b stream A", stream[15:0], 16'h000F);
    chk("b2b stream B", stream[31:16], 16'h0078);
    chk("b2b valid_count", vbits, 32);
    chk("b2b busy_drops", busy_drop, 0);
    chk("b2b done_count", nd, 2);
    chk("b2b done_cycle A", dc1, 17);
    chk("b2b done_cycle B", dc2, 34);

    // reset in FLUSH abandons the operation
    bad = 0;
    @(negedge clk);
    e8 = 8'hFF; start = 1'b1; drive_digits(8'h00, -1);
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (t == 12) chk("rst busy before reset", bz1, 1);
      if (t == 13)
        for (int i = 0; i < 4; i++)
          chk($sformatf("rst dut%0d outputs", i), {od_a[i], ov_a[i], bz_a[i], dn_a[i]}, 0);
      if (t >= 13 && (dn1 || ov1)) bad++;
      start = 1'b0;
      rst   = (t == 12);
      drive_digits(8'hAA, t - 1);
    end
    rst = 1'b0;
    chk("rst no_done_or_valid_after", bad, 0);
    run8(8'hFF, 8'hAA, 16'hA956, 16'h0056, 0, "post_rst");

    // 1024x1024: all-ones serial operand, alternating parallel operand
    ref_l = {{512{2'b10}}, 1024'b0} - {1024'b0, {512{2'b10}}};
    stream_l = '0; vb_l = 0; dc_l = 0; nd_l = 0;
    @(negedge clk);
    e_l = {512{2'b10}}; start_l = 1'b1; g_l = 1'b0;
    for (int t = 1; t <= 2060; t++) begin
      @(negedge clk);
      if (ov_l) begin
        if (vb_l < 2048) stream_l[vb_l] = o_l;
        vb_l++;
      end
      if (dn_l) begin
        dc_l = t;
        nd_l++;
      end
      start_l = 1'b0;
      e_l     = '0;
      g_l     = (t <= 1024);
    end
    checks++;
    if (stream_l !== ref_l) begin
      errors++;
      $display("FAIL big product: got low64 %0h expected low64 %0h",
               stream_l[63:0], ref_l[63:0]);
    end
    chk("big valid_count", vb_l, 2048);
    chk("big done_cycle", dc_l, 2049);
    chk("big done_count", nd_l, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_serial_digit_ctrl.md
# mult_serial_digit_ctrl

Digit-serial M×N-bit multiplier with start/done handshake, the parametrised successor of the team's bit-serial multiplier. It latches the M-bit parallel operand on `start` and consumes the N-bit serial operand D bits per cycle, LSB digit first. It streams the (N+M)-bit product D bits per cycle, LSB first, and supports unsigned or two's-complement operation. It sits between a serial operand source (garbled-input stream) and a serial result sink, and handles back-to-back operations without idle cycles.

## Interface
- `N`, 32, serial operand width; N % D == 0 required
- `M`, 32, parallel operand width; M % D == 0 required
- `D`, 1, digit width: bits consumed and produced per cycle
- `SIGNED`, 0, 0 = unsigned operands, 1 = two's-complement operands and product

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin operation; accepted only when `busy`=0 or `done`=1
- `e_init`  in  M  parallel operand, captured on the accepted `start` cycle
- `g_input`  in  D  serial operand digit, sampled in each of the N/D cycles after an accepted start
- `o`  out  D  product digit, LSB digit first
- `o_valid`  out  1  `o` carries a product digit
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse, coincident with the last product digit

## Operation
- States: IDLE, LOAD (N/D input digits), FLUSH (M/D zero digits). Digit counter width is ceil(log2((N+M)/D+1)).
- IDLE to LOAD on accepted `start`:
  - E <= `e_init`
  - accumulator P (M+D+1 bits) <= 0
  - counter <= 0
- Each LOAD/FLUSH cycle:
  - digit g = `g_input` in LOAD, 0 in FLUSH.
  - sum S = P + g·E
  - `o` <= S[D-1:0]
  - P <= S >> D
  - counter increments.
- Shift rule: logical shift when SIGNED=0, arithmetic shift when SIGNED=1.
- Operand interpretation for SIGNED=0: E and all digits are unsigned.
- Operand interpretation for SIGNED=1:
  - E is signed.
  - LOAD digits 0..N/D-2 are unsigned.
  - The final LOAD digit is a signed D-bit value, so its MSB carries negative weight.
  - FLUSH digits are 0; the arithmetic shift of P supplies the sign extension.
- Transitions:
  - LOAD to FLUSH after digit N/D-1.
  - FLUSH to IDLE after digit (N+M)/D-1, unless `start` is accepted in that cycle; then go directly to LOAD with the new E loaded.
- Result: the concatenated digits equal the exact product modulo 2^(N+M), as unsigned or two's complement per SIGNED.
- `start` while `busy`=1 and `done`=0 is ignored; the operation in flight is unaffected.
- `rst`=1 in any state:
  - next state is IDLE.
  - P, E and counter are cleared.
  - `o`, `o_valid`, `busy` and `done` are 0 from the next cycle.
  - any operation in flight is abandoned with no `done`.

## Timing
- Reset values: `o`=0, `o_valid`=0, `busy`=0, `done`=0.
- Cycle numbering: c0 is the cycle in which `start` is accepted.
- `g_input` digit k is sampled at the end of cycle c(k+1), for k = 0..N/D-1.
- Product digit j appears on `o` with `o_valid`=1 in cycle c(j+2), for j = 0..(N+M)/D-1. Latency is one cycle per digit.
- `busy`=1 from c1 through c((N+M)/D+1).
- `done`=1 only in c((N+M)/D+1), the cycle of the last digit.
- Back-to-back: a `start` accepted in the `done` cycle makes that cycle c0 of the next operation.
  - Next operation's first digit is sampled in the following cycle.
  - `o_valid` has exactly one gap cycle (the new c1) between streams.
  - `busy` stays 1 continuously.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- N=M=8, D=1, SIGNED=0, `e_init`=0xAA, serial 0xFF:
  - 16 digits form 0xA956.
  - `o_valid` is high for exactly 16 cycles, c2..c17.
  - `done` is high only in c17.
- Same operands with D=2, then D=4:
  - product 0xA956 in 8 and 4 digits respectively.
  - `done` in c9 and c5 respectively.
- N=M=8, D=2, SIGNED=1:
  - 0x80×0x80 gives 0x4000.
  - 0xFF×0x05 gives 0xFFFB.
  - 0x7F×0x80 gives 0xC080.
- Back-to-back, N=M=8, D=1:
  - A: 0x03×0x05; B: `start` asserted in A's `done` cycle with 0x0C×0x0A.
  - Streams read 0x000F then 0x0078.
  - One gap cycle between streams; `busy` never drops.
- Robustness:
  - `start` pulsed mid-LOAD is ignored; the product is unchanged.
  - `rst` asserted in FLUSH: outputs are 0 the next cycle and no `done` occurs.
  - A following operation after reset (0xFF×0xAA) still yields 0xA956.
- Large width, N=M=1024, D=1, SIGNED=0, serial all ones, `e_init` = alternating 10 pattern:
  - streamed product equals the reference multiplication.
  - error is 0.
